// File: rtl/sent_pkg.sv
// Shared SENT definitions: FSM states, tick constants, CRC-4 constants and
// the decoded frame payload. Also used by the transmitter side.
package sent_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HUNT,
        ST_STATUS,
        ST_DATA,
        ST_CRC
    } sent_state_e;

    localparam int unsigned SYNC_TICKS    = 56;
    localparam int unsigned NIB_OFFSET    = 12;
    localparam int unsigned NIB_MAX_TICKS = 27;

    localparam logic [3:0] CRC_SEED = 4'b0101;
    localparam logic [3:0] CRC_POLY = 4'hD;

    // One decoded frame as presented on the outputs.
    typedef struct packed {
        logic [3:0]  status;
        logic [23:0] data;
        logic [3:0]  crc;
    } sent_frame_t;

endpackage

// File: rtl/sent_crc4_step.sv
// One-nibble SENT CRC-4 update (x^4+x^3+x^2+1), zero-augmented form:
// four zero-shifts of crc_in, then XOR with nib.
//   crc_in  : running CRC
//   nib     : nibble to fold in
//   crc_out : updated CRC (combinational)
module sent_crc4_step
    import sent_pkg::*;
(
    input  logic [3:0] crc_in,
    input  logic [3:0] nib,
    output logic [3:0] crc_out
);

    logic [3:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 0; i < 4; i++) begin
            c = c[3] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        crc_out = c ^ nib;
    end

endmodule

// File: rtl/sent_rx_decoder.sv
// SENT frame receiver: times falling-edge intervals on the synchronized
// line, hunts for sync, decodes status/6 data/CRC nibbles and flags the
// result with one-cycle pulses.
//   clk_rx, reset_rx : clock, async active-low reset
//   sent_in          : raw SENT line (asynchronous)
//   status_out/data_out/crc_out : last completed frame (D0 in [23:20])
//   frame_valid / crc_err / frame_err : one-cycle result pulses
module sent_rx_decoder
    import sent_pkg::*;
#(
    parameter int unsigned TICK_CLKS = 4,
    parameter int unsigned SYNC_TOL  = 3,
    parameter int unsigned CNT_W     = 16
) (
    input  logic        clk_rx,
    input  logic        reset_rx,
    input  logic        sent_in,
    output logic [3:0]  status_out,
    output logic [23:0] data_out,
    output logic [3:0]  crc_out,
    output logic        frame_valid,
    output logic        crc_err,
    output logic        frame_err
);

    localparam int unsigned SHIFT = $clog2(TICK_CLKS);
    localparam int unsigned CW1   = CNT_W + 1;
    localparam logic [7:0] SYNC_LO = 8'(SYNC_TICKS - SYNC_TOL);
    localparam logic [7:0] SYNC_HI = 8'(SYNC_TICKS + SYNC_TOL);
    localparam logic [7:0] NIB_LO  = 8'(NIB_OFFSET);
    localparam logic [7:0] NIB_HI  = 8'(NIB_MAX_TICKS);

    logic             meta_q, cur_q, prev_q;
    logic             fall_c;
    logic [CNT_W-1:0] cnt_q, n_q;
    logic             ev_q;
    logic             sat_c;

    // Synchronizer plus edge-detect flop; idle-high line.
    always_ff @(posedge clk_rx or negedge reset_rx) begin
        if (!reset_rx) begin
            meta_q <= 1'b1;
            cur_q  <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= sent_in;
            cur_q  <= meta_q;
            prev_q <= cur_q;
        end
    end

    assign fall_c = prev_q & ~cur_q;
    assign sat_c  = &cnt_q;

    // Interval counter; the finished interval is latched with an event flag.
    always_ff @(posedge clk_rx or negedge reset_rx) begin
        if (!reset_rx) begin
            cnt_q <= '0;
            n_q   <= '0;
            ev_q  <= 1'b0;
        end else begin
            ev_q <= fall_c;
            if (fall_c) begin
                n_q   <= cnt_q;
                cnt_q <= CNT_W'(1);
            end else if (!sat_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Rounded cycles-to-ticks conversion by shift, clipped to 8 bits.
    logic [CW1-1:0] rnd_c, shr_c;
    logic [7:0]     ticks_c;
    logic [3:0]     nib_c;
    logic           nib_ok_c, sync_ok_c;

    always_comb begin
        rnd_c     = CW1'(n_q) + CW1'(TICK_CLKS / 2);
        shr_c     = rnd_c >> SHIFT;
        ticks_c   = (shr_c > CW1'(255)) ? 8'hFF : shr_c[7:0];
        nib_c     = 4'(ticks_c - NIB_LO);
        nib_ok_c  = (ticks_c >= NIB_LO) && (ticks_c <= NIB_HI);
        sync_ok_c = (ticks_c >= SYNC_LO) && (ticks_c <= SYNC_HI);
    end

    sent_state_e state_q, state_n;
    logic [2:0]  idx_q, idx_n;
    logic [3:0]  crc_q, crc_n, crc_upd_c, crc_fin_c;
    logic [3:0]  status_q, status_n;
    logic [23:0] data_q, data_n;
    sent_frame_t frame_q, frame_n;
    logic        fv_n, ce_n, fe_n;
    logic        fv_q, ce_q, fe_q;

    sent_crc4_step u_crc_upd (.crc_in(crc_q), .nib(nib_c), .crc_out(crc_upd_c));
    sent_crc4_step u_crc_fin (.crc_in(crc_q), .nib(4'h0),  .crc_out(crc_fin_c));

    // State and datapath registers.
    always_ff @(posedge clk_rx or negedge reset_rx) begin
        if (!reset_rx) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            crc_q    <= '0;
            status_q <= '0;
            data_q   <= '0;
            frame_q  <= '0;
            fv_q     <= 1'b0;
            ce_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            state_q  <= state_n;
            idx_q    <= idx_n;
            crc_q    <= crc_n;
            status_q <= status_n;
            data_q   <= data_n;
            frame_q  <= frame_n;
            fv_q     <= fv_n;
            ce_q     <= ce_n;
            fe_q     <= fe_n;
        end
    end

    // Next-state and output decisions, one per finished interval.
    always_comb begin
        state_n  = state_q;
        idx_n    = idx_q;
        crc_n    = crc_q;
        status_n = status_q;
        data_n   = data_q;
        frame_n  = frame_q;
        fv_n     = 1'b0;
        ce_n     = 1'b0;
        fe_n     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ev_q) state_n = ST_HUNT;
            end
            ST_HUNT: begin
                if (ev_q && sync_ok_c) state_n = ST_STATUS;
            end
            ST_STATUS, ST_DATA, ST_CRC: begin
                if (ev_q) begin
                    if (sync_ok_c) begin
                        fe_n    = 1'b1;
                        state_n = ST_STATUS;
                    end else if (!nib_ok_c) begin
                        fe_n    = 1'b1;
                        state_n = ST_HUNT;
                    end else if (state_q == ST_STATUS) begin
                        status_n = nib_c;
                        idx_n    = '0;
                        crc_n    = CRC_SEED;
                        state_n  = ST_DATA;
                    end else if (state_q == ST_DATA) begin
                        // Shift register: D0 ends up in the top nibble.
                        data_n = {data_q[19:0], nib_c};
                        crc_n  = crc_upd_c;
                        if (idx_q == 3'd5) begin
                            state_n = ST_CRC;
                        end else begin
                            idx_n = idx_q + 3'd1;
                        end
                    end else begin
                        frame_n = '{status: status_q, data: data_q, crc: nib_c};
                        if (crc_fin_c == nib_c) fv_n = 1'b1;
                        else                    ce_n = 1'b1;
                        state_n = ST_HUNT;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // A silent line drops back to IDLE without flagging anything.
        if (!ev_q && sat_c && (state_q != ST_IDLE)) state_n = ST_IDLE;
    end

    assign status_out  = frame_q.status;
    assign data_out    = frame_q.data;
    assign crc_out     = frame_q.crc;
    assign frame_valid = fv_q;
    assign crc_err     = ce_q;
    assign frame_err   = fe_q;

endmodule

// File: tb/tb_sent_rx_decoder.sv
// Randomized scoreboard bench for sent_rx_decoder: builds SENT waveforms
// from nibble values, predicts each frame outcome and checks the pulses and
// output registers as the DUT presents them.
module tb_sent_rx_decoder;

    localparam int TICK = 4;
    localparam int LOW  = 5 * TICK;

    localparam int K_VALID = 0;
    localparam int K_CRC   = 1;
    localparam int K_FRAME = 2;

    logic        clk_rx = 1'b0;
    logic        reset_rx;
    logic        sent_in;
    logic [3:0]  status_out;
    logic [23:0] data_out;
    logic [3:0]  crc_out;
    logic        frame_valid, crc_err, frame_err;

    always #5 clk_rx = ~clk_rx;

    sent_rx_decoder #(.TICK_CLKS(TICK), .SYNC_TOL(3), .CNT_W(16)) dut (
        .clk_rx      (clk_rx),
        .reset_rx    (reset_rx),
        .sent_in     (sent_in),
        .status_out  (status_out),
        .data_out    (data_out),
        .crc_out     (crc_out),
        .frame_valid (frame_valid),
        .crc_err     (crc_err),
        .frame_err   (frame_err)
    );

    typedef struct {
        int         kind;
        logic [3:0] st;
        logic [23:0] d;
        logic [3:0] c;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // CRC as remainder of {seed, D0..D5, 0000} divided by x^4+x^3+x^2+1.
    function automatic logic [3:0] ref_crc(input logic [23:0] d);
        logic [31:0] v;
        v = {4'b0101, d, 4'h0};
        for (int i = 31; i >= 4; i--) begin
            if (v[i]) v = v ^ (32'h1D << (i - 4));
        end
        return v[3:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One interval: falling edge, low pulse, then high for the remainder.
    task automatic send_interval(input int cycles);
        @(negedge clk_rx) sent_in = 1'b0;
        repeat (LOW - 1) @(negedge clk_rx);
        sent_in = 1'b1;
        repeat (cycles - LOW) @(negedge clk_rx);
    endtask

    function automatic int nib_cycles(input logic [3:0] v);
        return (12 + int'(v)) * TICK + int'($urandom_range(0, 2)) - 1;
    endfunction

    // Sends sync + status + data + CRC; the CRC interval is closed by the
    // next edge the bench produces. accepted=0 means sync out of tolerance.
    task automatic send_frame(input logic [3:0] st, input logic [23:0] d,
                              input logic [3:0] c, input int sync_cyc,
                              input bit accepted);
        exp_t e;
        if (accepted) begin
            e.kind = (c == ref_crc(d)) ? K_VALID : K_CRC;
            e.st = st; e.d = d; e.c = c;
            q.push_back(e);
        end
        send_interval(sync_cyc);
        send_interval(nib_cycles(st));
        for (int i = 0; i < 6; i++) send_interval(nib_cycles(d[23-4*i -: 4]));
        send_interval(nib_cycles(c));
    endtask

    // Monitor: pops one expectation per pulse.
    exp_t m_e;
    int   m_n;
    int   m_kind;
    always @(negedge clk_rx) begin
        if (reset_rx) begin
            m_n = int'(frame_valid) + int'(crc_err) + int'(frame_err);
            if (m_n > 1) begin
                checks++;
                errors++;
                $display("FAIL pulse_onehot actual=%0d required=1", m_n);
            end
            if (m_n >= 1) begin
                m_kind = frame_valid ? K_VALID : (crc_err ? K_CRC : K_FRAME);
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse actual=kind%0d required=none", m_kind);
                end else begin
                    m_e = q.pop_front();
                    if (m_kind != m_e.kind) begin
                        errors++;
                        $display("FAIL pulse_kind actual=%0d required=%0d", m_kind, m_e.kind);
                    end else if (m_kind != K_FRAME) begin
                        chk("status_out", 32'(status_out), 32'(m_e.st));
                        chk("data_out",   32'(data_out),   32'(m_e.d));
                        chk("crc_out",    32'(crc_out),    32'(m_e.c));
                    end
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_status"}, 32'(status_out), 32'h0);
        chk({tag, "_data"},   32'(data_out),   32'h0);
        chk({tag, "_crc"},    32'(crc_out),    32'h0);
        chk({tag, "_pulses"}, 32'({frame_valid, crc_err, frame_err}), 32'h0);
    endtask

    initial begin
        logic [3:0]  st;
        logic [23:0] d;
        logic [3:0]  c;
        exp_t        e;
        int          budget;

        sent_in  = 1'b1;
        reset_rx = 1'b0;
        repeat (5) @(negedge clk_rx);
        check_outputs_zero("reset");
        reset_rx = 1'b1;
        repeat (20) @(negedge clk_rx);

        // Zero frame with good then bad CRC, back to back.
        send_frame(4'h0, 24'h000000, 4'h5, 224, 1'b1);
        send_frame(4'h0, 24'h000000, 4'h6, 224, 1'b1);

        // All-ones data, back to back, then after a pause.
        st = 4'($urandom);
        send_frame(st, 24'hFFFFFF, ref_crc(24'hFFFFFF), 224, 1'b1);
        send_frame(4'hA, 24'hFFFFFF, ref_crc(24'hFFFFFF), 224, 1'b1);
        send_interval(500);
        send_frame(4'h3, 24'hFFFFFF, ref_crc(24'hFFFFFF), 224, 1'b1);

        // Third data nibble too short: frame_err, then a clean frame.
        e.kind = K_FRAME; e.st = 0; e.d = 0; e.c = 0;
        q.push_back(e);
        send_interval(224);
        send_interval(nib_cycles(4'h2));
        send_interval(nib_cycles(4'h7));
        send_interval(nib_cycles(4'h1));
        send_interval(40);
        send_frame(4'h5, 24'h123456, ref_crc(24'h123456), 224, 1'b1);

        // Sync tolerance edges: 59 ticks accepted, 61 rejected.
        send_frame(4'h9, 24'hABCDEF, ref_crc(24'hABCDEF), 236, 1'b1);
        send_frame(4'h1, 24'h111111, ref_crc(24'h111111), 244, 1'b0);
        send_frame(4'hC, 24'h0F0F0F, ref_crc(24'h0F0F0F), 224, 1'b1);

        // Randomized frames, mostly good CRC, optional pauses.
        for (int n = 0; n < 16; n++) begin
            st = 4'($urandom);
            d  = 24'($urandom);
            c  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ref_crc(d);
            send_frame(st, d, c, int'($urandom_range(214, 234)), 1'b1);
            if ($urandom_range(0, 1) == 1) send_interval(int'($urandom_range(300, 600)));
        end

        // Reset during D3: no pulse, outputs cleared, next frame decodes.
        send_interval(224);
        send_interval(nib_cycles(4'h4));
        send_interval(nib_cycles(4'h8));
        send_interval(nib_cycles(4'h2));
        send_interval(nib_cycles(4'hE));
        @(negedge clk_rx) sent_in = 1'b0;
        repeat (10) @(negedge clk_rx);
        reset_rx = 1'b0;
        sent_in  = 1'b1;
        repeat (3) @(negedge clk_rx);
        check_outputs_zero("midreset");
        reset_rx = 1'b1;
        repeat (30) @(negedge clk_rx);
        send_frame(4'h6, 24'h5A5A5A, ref_crc(24'h5A5A5A), 224, 1'b1);
        send_interval(500);

        budget = 200;
        while (q.size() != 0 && budget > 0) begin
            @(negedge clk_rx);
            budget--;
        end
        chk("pending_expectations", 32'(q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
